// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for a 5-stage in-order core. It covers:
//   - load-use stalls (one bubble into ID/EX)
//   - taken-branch flushes of IF/ID and ID/EX
//   - freezing the front of the pipe while a multicycle mul/div runs,
//     with a timeout that raises a sticky error flag
//
// Parameters:
//   MD_MAX_CYC   cycles allowed in MD_WAIT before timeout (2..255)
//
// Optional feature:
//   HAZARD_STALL_CNT_EN  when defined, stall_cnt counts cycles with
//                        pc_wr_en=0, saturating. When undefined, stall_cnt
//                        is tied to 0.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_rs, id_rs2, id_uses_rs2    source operands of the instruction in ID
//   id_ex_memrd, id_ex_rd         EX instruction is a load / its dest reg
//   ex_md_start                   multicycle op issued in EX this cycle
//   md_done                       multicycle result valid (1-cycle pulse)
//   ex_br_taken                   branch/jump in EX resolved taken
//   pc_wr_en, if_id_wr_en,
//   id_ex_wr_en                   pipeline register write enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush                  bubble insertion into the named register
//   md_timeout                    sticky multicycle timeout flag
//   stall_cnt                     stall-cycle counter
module hazard_ctrl #(
  parameter int unsigned MD_MAX_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        id_ex_memrd,
  input  logic [4:0]  id_ex_rd,
  input  logic        ex_md_start,
  input  logic        md_done,
  input  logic        ex_br_taken,
  output logic        pc_wr_en,
  output logic        if_id_wr_en,
  output logic        id_ex_wr_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_timeout,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_WAIT = 2'd1;
  localparam logic [1:0] ST_LU_BUB  = 2'd2;

  // Last counter value in MD_WAIT before giving up on md_done.
  localparam logic [7:0] MD_LAST = 8'(MD_MAX_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       md_timeout_q, md_timeout_d;
  logic       lu_hit;

  // x0 never carries a real dependency, so a load into x0 cannot stall.
  assign lu_hit = id_ex_memrd && (id_ex_rd != 5'd0) &&
                  ((id_ex_rd == id_rs) || (id_uses_rs2 && (id_ex_rd == id_rs2)));

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    md_timeout_d = md_timeout_q;
    pc_wr_en     = 1'b1;
    if_id_wr_en  = 1'b1;
    id_ex_wr_en  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    case (state_q)
      ST_RUN: begin
        // A taken branch kills the younger instructions, so any load-use
        // hazard they carry is moot: flush only, never stall.
        if (ex_br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_md_start) begin
          state_d  = ST_MD_WAIT;
          md_cnt_d = 8'd0;
        end else if (lu_hit) begin
          pc_wr_en    = 1'b0;
          if_id_wr_en = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = ST_LU_BUB;
        end
      end

      ST_MD_WAIT: begin
        // A timeout releases the pipe exactly as a normal completion would.
        if (md_done) begin
          state_d = ST_RUN;
        end else if (md_cnt_q == MD_LAST) begin
          md_timeout_d = 1'b1;
          state_d      = ST_RUN;
        end else begin
          pc_wr_en     = 1'b0;
          if_id_wr_en  = 1'b0;
          id_ex_wr_en  = 1'b0;
          ex_mem_flush = 1'b1;
          md_cnt_d     = md_cnt_q + 8'd1;
        end
      end

      // The load has now left EX, so the stalled instruction can proceed;
      // detection is masked because id_ex still holds the bubble's view.
      ST_LU_BUB: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Hold the pipe in its free-running configuration while reset is low,
    // so an abandoned multicycle wait never glitches a flush.
    if (!rst_n) begin
      pc_wr_en     = 1'b1;
      if_id_wr_en  = 1'b1;
      id_ex_wr_en  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      md_cnt_q     <= 8'd0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign md_timeout = md_timeout_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturate rather than wrap so a long-running count never looks small.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_wr_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl. Two instances share all
// inputs: dut_a uses the default MD_MAX_CYC (64), dut_b uses MD_MAX_CYC=8
// so the timeout path can be reached quickly. Inputs change on the falling
// edge and outputs are sampled 1ns later, well away from the rising edge.
// Control outputs are packed as
//   {pc_wr_en, if_id_wr_en, id_ex_wr_en, if_id_flush, id_ex_flush, ex_mem_flush}
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rs2, id_ex_rd;
  logic        id_uses_rs2, id_ex_memrd, ex_md_start, md_done, ex_br_taken;

  logic        pc_wr_en_a, if_id_wr_en_a, id_ex_wr_en_a;
  logic        if_id_flush_a, id_ex_flush_a, ex_mem_flush_a, md_timeout_a;
  logic [31:0] stall_cnt_a;
  logic        pc_wr_en_b, if_id_wr_en_b, id_ex_wr_en_b;
  logic        if_id_flush_b, id_ex_flush_b, ex_mem_flush_b, md_timeout_b;
  logic [31:0] stall_cnt_b;
  logic [5:0]  ctrl_a, ctrl_b;

  int compare_cnt = 0;
  int fail_cnt    = 0;
  int exp_stall   = 0;

  localparam logic [5:0] RUN_OUT = 6'b111_000;
  localparam logic [5:0] BR_OUT  = 6'b111_110;
  localparam logic [5:0] LU_OUT  = 6'b001_010;
  localparam logic [5:0] MD_OUT  = 6'b000_001;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_memrd(id_ex_memrd), .id_ex_rd(id_ex_rd),
    .ex_md_start(ex_md_start), .md_done(md_done), .ex_br_taken(ex_br_taken),
    .pc_wr_en(pc_wr_en_a), .if_id_wr_en(if_id_wr_en_a), .id_ex_wr_en(id_ex_wr_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .ex_mem_flush(ex_mem_flush_a),
    .md_timeout(md_timeout_a), .stall_cnt(stall_cnt_a)
  );

  hazard_ctrl #(.MD_MAX_CYC(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_ex_memrd(id_ex_memrd), .id_ex_rd(id_ex_rd),
    .ex_md_start(ex_md_start), .md_done(md_done), .ex_br_taken(ex_br_taken),
    .pc_wr_en(pc_wr_en_b), .if_id_wr_en(if_id_wr_en_b), .id_ex_wr_en(id_ex_wr_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .ex_mem_flush(ex_mem_flush_b),
    .md_timeout(md_timeout_b), .stall_cnt(stall_cnt_b)
  );

  assign ctrl_a = {pc_wr_en_a, if_id_wr_en_a, id_ex_wr_en_a, if_id_flush_a, id_ex_flush_a, ex_mem_flush_a};
  assign ctrl_b = {pc_wr_en_b, if_id_wr_en_b, id_ex_wr_en_b, if_id_flush_b, id_ex_flush_b, ex_mem_flush_b};

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle for 1ns.
  task automatic applyStimulus(input logic br, input logic ms, input logic done,
                               input logic memrd, input logic [4:0] ex_rd,
                               input logic [4:0] rs, input logic [4:0] rs2,
                               input logic uses2);
    @(negedge clk);
    ex_br_taken = br;
    ex_md_start = ms;
    md_done     = done;
    id_ex_memrd = memrd;
    id_ex_rd    = ex_rd;
    id_rs       = rs;
    id_rs2      = rs2;
    id_uses_rs2 = uses2;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic luCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
  endtask

  task automatic bumpStall(input int n);
    if (STALL_EN) exp_stall += n;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_stall = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    ex_br_taken = 1'b1;
    ex_md_start = 1'b0;
    md_done     = 1'b0;
    id_ex_memrd = 1'b1;
    id_ex_rd    = 5'd5;
    id_rs       = 5'd5;
    id_rs2      = 5'd0;
    id_uses_rs2 = 1'b0;

    // Reset state: defaults even with branch and load-use inputs active
    #3;
    checkOutput("reset_ctrl", ctrl_a, RUN_OUT);
    checkOutput("reset_timeout", md_timeout_a, 0);
    checkOutput("reset_stall", stall_cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ex_br_taken = 1'b0;
    id_ex_memrd = 1'b0;

    idleCycle();
    checkOutput("run_idle", ctrl_a, RUN_OUT);

    // Load-use on rs: stall, bubble, then detection live again
    luCycle();
    checkOutput("lu_stall", ctrl_a, LU_OUT);
    bumpStall(1);
    luCycle();
    checkOutput("lu_bubble_masked", ctrl_a, RUN_OUT);
    luCycle();
    checkOutput("lu_stall_again", ctrl_a, LU_OUT);
    bumpStall(1);
    idleCycle();
    checkOutput("lu_bubble2", ctrl_a, RUN_OUT);
    checkOutput("lu_stall_cnt", stall_cnt_a, exp_stall);

    // No-stall cases: rd=x0, rs2 match without rs2 use
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("lu_rd_zero", ctrl_a, RUN_OUT);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
    checkOutput("lu_rs2_unused", ctrl_a, RUN_OUT);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
    checkOutput("lu_rs2_used", ctrl_a, LU_OUT);
    bumpStall(1);
    idleCycle();
    checkOutput("lu_rs2_bubble", ctrl_a, RUN_OUT);

    // Branch with simultaneous load-use: flush only, stay in RUN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    checkOutput("br_with_lu", ctrl_a, BR_OUT);
    luCycle();
    checkOutput("br_stayed_run", ctrl_a, LU_OUT);
    bumpStall(1);
    idleCycle();
    checkOutput("br_lu_bubble", ctrl_a, RUN_OUT);

    // md_done outside MD_WAIT is ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("done_in_run", ctrl_a, RUN_OUT);

    // Multicycle op on dut_a: 10 stall cycles; branch/lu/start ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("md_start", ctrl_a, RUN_OUT);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], i[1], 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
      checkOutput($sformatf("md_wait_%0d", i), ctrl_a, MD_OUT);
    end
    bumpStall(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("md_done_release", ctrl_a, RUN_OUT);
    luCycle();
    checkOutput("md_back_in_run", ctrl_a, LU_OUT);
    bumpStall(1);
    idleCycle();
    checkOutput("md_stall_cnt", stall_cnt_a, exp_stall);
    checkOutput("md_no_timeout", md_timeout_a, 0);

    // dut_b: md_done on the last allowed cycle is a normal completion
    pulseReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      idleCycle();
      checkOutput($sformatf("b_edge_wait_%0d", i), ctrl_b, MD_OUT);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("b_edge_done", ctrl_b, RUN_OUT);
    idleCycle();
    checkOutput("b_edge_no_timeout", md_timeout_b, 0);

    // dut_b timeout after 8 wait cycles; dut_a keeps waiting (limit 64)
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    checkOutput("b_md_start", ctrl_b, RUN_OUT);
    for (int i = 0; i < 7; i++) begin
      idleCycle();
      checkOutput($sformatf("b_wait_%0d", i), ctrl_b, MD_OUT);
    end
    idleCycle();
    checkOutput("b_timeout_release", ctrl_b, RUN_OUT);
    checkOutput("b_timeout_not_yet", md_timeout_b, 0);
    luCycle();
    checkOutput("b_timeout_run", ctrl_b, LU_OUT);
    checkOutput("b_timeout_set", md_timeout_b, 1);
    for (int i = 0; i < 3; i++) idleCycle();
    checkOutput("b_timeout_held", md_timeout_b, 1);

    // Async reset while dut_a is mid-MD_WAIT
    idleCycle();
    checkOutput("a_still_waiting", ctrl_a, MD_OUT);
    #1;
    rst_n = 1'b0;
    exp_stall = 0;
    #1;
    checkOutput("async_rst_ctrl", ctrl_a, RUN_OUT);
    checkOutput("async_rst_timeout", md_timeout_b, 0);
    checkOutput("async_rst_stall", stall_cnt_a, 0);

    // Held in reset: load-use hit must not stall; after release it does
    luCycle();
    checkOutput("rst_masks_lu", ctrl_a, RUN_OUT);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_lu", ctrl_a, LU_OUT);
    bumpStall(1);
    luCycle();
    checkOutput("post_rst_bubble", ctrl_a, RUN_OUT);
    idleCycle();
    checkOutput("post_rst_stall_cnt", stall_cnt_a, exp_stall);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
    $finish;
  end

endmodule
